// File: rtl/param_serial_adder.sv
// param_serial_adder: bit-serial ripple adder, one operand bit per clock, valid/ready handshakes
module param_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb, res;
  logic [CW-1:0] cnt;
  logic c, s, co;
  assign s  = sa[0] ^ sb[0] ^ c;
  assign co = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
  // accept operands, ripple one bit per RUN edge LSB first, hold the result until handed off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      res       <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sa       <= a;
          sb       <= b;
          c        <= 1'b0;
          cnt      <= '0;
          state    <= RUN;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          c   <= co;
          res <= {s, res[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            sum       <= {s, res[WIDTH-1:1]};
            carry_out <= co;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_param_serial_adder.sv
// tb_param_serial_adder: scoreboard bench over WIDTH 4, 8 and 16 instances
module tb_param_serial_adder;
  typedef struct {
    logic [32:0] e;
    int          acc;
  } item_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  bit done [3];

  task automatic chk(input string n, input int w, input logic [32:0] act, input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s W=%0d actual=%h required=%h", n, w, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int W = 4 << g;
    logic rst_n, in_valid, in_ready, carry_out, out_valid, out_ready, busy;
    logic rnd, or_dir, pv, hand;
    logic [W-1:0] a, b, sum;
    int cyc;
    item_t q[$];
    item_t cur;

    param_serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sum(sum), .carry_out(carry_out),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    initial begin
      cyc = 0;
      forever @(posedge clk) cyc++;
    end

    initial begin
      out_ready = 1'b1;
      forever begin
        @(posedge clk);
        #2;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : or_dir;
      end
    end

    initial begin
      pv = 1'b0;
      hand = 1'b0;
      forever begin
        @(negedge clk);
        if (rst_n) begin
          chk("busy", W, busy, !in_ready);
          if (hand) begin
            chk("handoff_ov", W, out_valid, 0);
            chk("handoff_rdy", W, in_ready, 1);
          end
          if (out_valid && !pv) begin
            if (q.size() == 0) chk("spurious_ov", W, out_valid, 0);
            else begin
              cur = q.pop_front();
              chk("latency", W, cyc - cur.acc, W);
            end
          end
          if (out_valid) chk("result", W, {carry_out, sum}, cur.e);
          hand = out_valid && out_ready;
          pv = out_valid;
        end else begin
          hand = 1'b0;
          pv = 1'b0;
        end
      end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
      int n;
      a = x;
      b = y;
      in_valid = 1'b1;
      for (n = 0; n < 100 && !in_ready; n++) begin
        @(posedge clk);
        #1;
      end
      chk("accept_timeout", W, in_ready, 1);
      q.push_back('{e: 33'(x) + 33'(y), acc: cyc + 1});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int n;
      for (n = 0; n < 500 && (q.size() != 0 || !in_ready); n++) begin
        @(posedge clk);
        #1;
      end
      chk("idle_timeout", W, n < 500, 1);
    endtask

    task automatic chk_reset(input string n);
      chk({n, "_rdy"}, W, in_ready, 1);
      chk({n, "_busy"}, W, busy, 0);
      chk({n, "_ov"}, W, out_valid, 0);
      chk({n, "_sum"}, W, sum, 0);
      chk({n, "_co"}, W, carry_out, 0);
    endtask

    initial begin
      logic [W-1:0] x, y;
      int n;
      rst_n = 1'b0;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      rnd = 1'b0;
      or_dir = 1'b1;
      @(posedge clk);
      #1;
      chk_reset("reset");
      #3;
      rst_n = 1'b1;
      send(W'(8'h12), W'(8'h05));
      wait_idle();
      send('1, 1);
      send('1, '1);
      send(0, 0);
      wait_idle();
      or_dir = 1'b0;
      send(W'(8'h0A), W'(8'h0F));
      for (n = 0; n < 100 && !out_valid; n++) begin
        @(posedge clk);
        #1;
      end
      repeat (5) begin
        @(negedge clk);
        chk("bp_valid", W, out_valid, 1);
        chk("bp_result", W, {carry_out, sum}, 33'(W'(8'h0A)) + 33'(W'(8'h0F)));
      end
      @(posedge clk);
      #1;
      or_dir = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_handoff_ov", W, out_valid, 0);
      chk("bp_handoff_rdy", W, in_ready, 1);
      wait_idle();
      x = W'(8'h5C);
      y = W'(8'h3B);
      a = x;
      b = y;
      in_valid = 1'b1;
      q.push_back('{e: 33'(x) + 33'(y), acc: cyc + 1});
      @(posedge clk);
      for (int i = 0; i < W - 2; i++) begin
        #1;
        a = W'($urandom);
        b = W'($urandom);
        chk("scramble_rdy", W, in_ready, 0);
        @(posedge clk);
      end
      #1;
      in_valid = 1'b0;
      wait_idle();
      send(W'(8'h12), W'(8'h34));
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      q.delete();
      #1;
      chk_reset("abort");
      @(posedge clk);
      #1;
      chk("abort_hold_ov", W, out_valid, 0);
      #2;
      rst_n = 1'b1;
      repeat (W + 4) @(posedge clk);
      #1;
      send(W'(8'h01), W'(8'h02));
      wait_idle();
      rnd = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        send(W'($urandom), W'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      rnd = 1'b0;
      wait_idle();
      done[g] = 1'b1;
    end
  end

  initial begin
    int n;
    for (n = 0; n < 90000 && !(done[0] && done[1] && done[2]); n++) @(posedge clk);
    chk("global_timeout", 0, done[0] && done[1] && done[2], 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
